ps2_tx: RTL and testbench

Device-side PS/2 frame transmitter. It takes a byte through a valid/ready handshake and drives an 11-bit frame onto open-collector-style `ps2_clk` and `ps2_dat` lines. The frame is start 0, eight data bits LSB first, odd parity, and stop 1. Data changes while the clock is high and is sampled by the host on the falling clock edge. It pairs with the team's PS/2 receiver and replaces the behavioural bit-pusher in benches, so receiver loopback tests run fully in RTL.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_quarter_tick.sv | 33 +++
 rtl/ps2_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame layout, parity helper and transmitter state encoding.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned BIT_IDX_W  = $clog2(FRAME_BITS);
  localparam int unsigned PHASE_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } ps2_tx_state_t;

  // Wire order on the line is start first, so start sits at bit 0.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic ps2_frame_t make_frame(input logic [7:0] data);
    ps2_frame_t f;
    f.stop   = STOP_BIT;
    f.parity = odd_parity(data);
    f.data   = data;
    f.start  = START_BIT;
    return f;
  endfunction

endpackage

// File: rtl/ps2_quarter_tick.sv
// Quarter-bit prescaler: tick marks every QUARTER-th edge counted from the cycle restart is high.
module ps2_quarter_tick #(
  parameter int unsigned QUARTER = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned    CNT_W       = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(QUARTER - 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'((QUARTER > 1) ? 1 : 0);
  localparam logic           ONE_CYCLE   = (QUARTER == 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The restart cycle itself counts as the first cycle of the first quarter.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    tick  = (cnt_q == CNT_LAST);
    if (restart) begin
      cnt_d = CNT_START;
      tick  = ONE_CYCLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps2_tx.sv
// Device-side PS/2 frame transmitter: byte handshake in, open-collector style clock/data frame out.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned QUARTER      = 25,
  parameter int unsigned GAP_QUARTERS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_dat,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int unsigned GAP_W = (GAP_QUARTERS > 0) ? $clog2(GAP_QUARTERS + 1) : 1;
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_QUARTERS > 0) ? GAP_QUARTERS - 1 : 0);
  localparam logic                 NO_GAP   = (GAP_QUARTERS == 0);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(FRAME_BITS - 1);

  ps2_tx_state_t           state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [BIT_IDX_W-1:0]    bit_q, bit_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    clk_q, clk_d;
  logic                    dat_q, dat_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;
  logic                    busy_q, busy_d;
  logic                    accept_c;
  logic                    tick_c;
  logic                    step_c;

  assign in_ready = (state_q == ST_IDLE) && !inhibit;
  assign accept_c = in_valid && in_ready;

  ps2_quarter_tick #(.QUARTER(QUARTER)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept_c),
    .tick    (tick_c)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    clk_d   = clk_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    step_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SEND;
          frame_d = make_frame(in_data);
          bit_d   = '0;
          phase_d = '0;
          step_c  = tick_c;
        end
      end
      ST_SEND: step_c = tick_c;
      ST_GAP: begin
        if (NO_GAP) begin
          state_d = ST_IDLE;
        end else if (tick_c) begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // One quarter of the current bit; a single-cycle quarter may land on the accept edge.
    if (step_c) begin
      unique case (phase_d)
        2'd0: begin
          dat_d   = frame_d[0];
          phase_d = 2'd1;
        end
        2'd1: begin
          clk_d   = 1'b0;
          phase_d = 2'd2;
        end
        2'd2: phase_d = 2'd3;
        default: begin
          clk_d   = 1'b1;
          phase_d = 2'd0;
          if (bit_d == BIT_LAST) begin
            state_d = ST_GAP;
            dat_d   = 1'b1;
            done_d  = 1'b1;
            bit_d   = '0;
          end else if (inhibit) begin
            state_d = ST_GAP;
            dat_d   = 1'b1;
            abort_d = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d   = bit_d + BIT_IDX_W'(1);
            frame_d = {STOP_BIT, frame_d[FRAME_BITS-1:1]};
          end
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      gap_q   <= '0;
      clk_q   <= 1'b1;
      dat_q   <= 1'b1;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      clk_q   <= clk_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign ps2_clk = clk_q;
  assign ps2_dat = dat_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = abort_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: two instances (QUARTER=4/GAP=4 and QUARTER=1/GAP=0) checked against a waveform model.
module tb_ps2_tx;

  localparam int QA = 4;
  localparam int GA = 4;
  localparam int QB = 1;
  localparam int GB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic       a_reset, a_valid, a_inhibit, a_ready, a_clk, a_dat, a_busy, a_done, a_abort;
  logic [7:0] a_data;
  logic       b_reset, b_valid, b_inhibit, b_ready, b_clk, b_dat, b_busy, b_done, b_abort;
  logic [7:0] b_data;

  ps2_tx #(.QUARTER(QA), .GAP_QUARTERS(GA)) dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .inhibit(a_inhibit), .ps2_clk(a_clk), .ps2_dat(a_dat), .busy(a_busy), .done(a_done),
    .aborted(a_abort)
  );

  ps2_tx #(.QUARTER(QB), .GAP_QUARTERS(GB)) dut_b (
    .clk(clk), .reset(b_reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .inhibit(b_inhibit), .ps2_clk(b_clk), .ps2_dat(b_dat), .busy(b_busy), .done(b_done),
    .aborted(b_abort)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit sb, input logic v, input logic [7:0] d);
    if (sb) begin b_valid = v; b_data = d; end
    else    begin a_valid = v; a_data = d; end
  endtask

  task automatic set_inh(input bit sb, input logic v);
    if (sb) b_inhibit = v;
    else    a_inhibit = v;
  endtask

  function automatic logic cur_inh(input bit sb);
    return sb ? b_inhibit : a_inhibit;
  endfunction

  // {ps2_clk, ps2_dat, done, aborted, busy, in_ready}
  function automatic logic [5:0] obs(input bit sb);
    if (sb) return {b_clk, b_dat, b_done, b_abort, b_busy, b_ready};
    return {a_clk, a_dat, a_done, a_abort, a_busy, a_ready};
  endfunction

  // Frame bits in line order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Expected outputs k cycles after the handshake cycle, derived from the quarter timing.
  function automatic logic [5:0] ref_obs(input int k, input int q, input int g,
                                         input logic [10:0] fb, input int inh, input logic inh_now);
    int   end_k, gap_len, qi, n, ph;
    logic e_clk, e_dat, e_busy, e_done, e_abort;
    end_k   = (inh >= 0) ? (inh + 1) * 4 * q : 44 * q;
    gap_len = (g == 0) ? 1 : g * q;
    e_clk   = 1'b1;
    e_dat   = 1'b1;
    if (k < end_k) begin
      qi    = k / q;
      n     = qi / 4;
      ph    = qi % 4;
      e_clk = (ph < 2);
      if (ph == 0) e_dat = (n == 0) ? 1'b1 : fb[n-1];
      else         e_dat = fb[n];
    end
    e_busy  = (k >= 1) && (k < end_k + gap_len);
    e_done  = (k == end_k) && (inh < 0);
    e_abort = (k == end_k) && (inh >= 0);
    return {e_clk, e_dat, e_done, e_abort, e_busy, !e_busy && !inh_now};
  endfunction

  task automatic wait_accept(input bit sb, output int c);
    logic [5:0] o;
    c = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      o = obs(sb);
      if (o[0]) begin
        c = cyc;
        break;
      end
    end
    check("accept_within_budget", 32'(c >= 0), 32'(1));
  endtask

  task automatic check_frame(input bit sb, input int c, input logic [7:0] d, input int inh,
                             output logic [10:0] got, output int nfall);
    int         q, g, end_k, gap_len;
    logic [10:0] fb;
    logic [5:0] o, e;
    logic       prev_clk;
    q        = sb ? QB : QA;
    g        = sb ? GB : GA;
    fb       = ref_frame(d);
    end_k    = (inh >= 0) ? (inh + 1) * 4 * q : 44 * q;
    gap_len  = (g == 0) ? 1 : g * q;
    got      = '0;
    nfall    = 0;
    prev_clk = 1'b1;
    for (int k = 1; k <= end_k + gap_len; k++) begin
      @(negedge clk);
      if (k == 1) drive(sb, 1'b0, ~d);
      if (inh >= 0 && k == inh * 4 * q + 2 * q) set_inh(sb, 1'b1);
      if (k == end_k + 1) set_inh(sb, 1'b0);
      #1;
      o = obs(sb);
      e = ref_obs(k, q, g, fb, inh, cur_inh(sb));
      check($sformatf("wave%0d k=%0d", sb, k + 0 * c), 32'(o), 32'(e));
      if (prev_clk && !o[5]) begin
        if (nfall < 11) got[nfall] = o[4];
        nfall++;
      end
      prev_clk = o[5];
    end
  endtask

  task automatic send(input bit sb, input logic [7:0] d, input int inh,
                      output logic [10:0] got, output int nfall);
    int c;
    got   = '0;
    nfall = 0;
    drive(sb, 1'b1, d);
    wait_accept(sb, c);
    if (c >= 0) check_frame(sb, c, d, inh, got, nfall);
    else        drive(sb, 1'b0, d);
  endtask

  // 0x00 then 0x07 with valid held high; measures accept-to-accept spacing.
  task automatic back_to_back(input bit sb, input int exp_gap);
    int          c1, c2, nf;
    logic [10:0] got;
    logic [5:0]  o;
    logic        prev;
    drive(sb, 1'b1, 8'h00);
    wait_accept(sb, c1);
    if (c1 < 0) return;
    c2 = -1; nf = 0; got = '0; prev = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) drive(sb, 1'b1, 8'h07);
      #1;
      o = obs(sb);
      if (prev && !o[5]) begin
        if (nf < 11) got[nf] = o[4];
        nf++;
      end
      prev = o[5];
      if (o[0]) begin
        c2 = cyc;
        break;
      end
    end
    check($sformatf("b2b_spacing%0d", sb), 32'(c2 - c1), 32'(exp_gap));
    check($sformatf("b2b_falls0_%0d", sb), 32'(nf), 32'(11));
    check($sformatf("b2b_frame0_%0d", sb), 32'(got), 32'(11'b11000000000));
    check($sformatf("b2b_par0_%0d", sb), 32'(got[9]), 32'(1));
    if (c2 >= 0) begin
      check_frame(sb, c2, 8'h07, -1, got, nf);
      check($sformatf("b2b_frame1_%0d", sb), 32'(got), 32'(11'b10000001110));
      check($sformatf("b2b_par1_%0d", sb), 32'(got[9]), 32'(0));
    end else begin
      drive(sb, 1'b0, 8'h00);
    end
  endtask

  typedef struct {
    bit          sb;
    logic [7:0]  data;
    int          inh;
    logic [10:0] frame;
    int          falls;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vt[8];
    logic [10:0] got, fb;
    logic [7:0]  d;
    int          nf, inh, c;
    bit          sb;

    vt[0] = '{1'b0, 8'hA5, -1, 11'b11101001010, 11};
    vt[1] = '{1'b0, 8'h00, -1, 11'b11000000000, 11};
    vt[2] = '{1'b0, 8'h07, -1, 11'b10000001110, 11};
    vt[3] = '{1'b0, 8'hFF,  3, 11'b11111111110, 4};
    vt[4] = '{1'b0, 8'h3C, -1, 11'b11001111000, 11};
    vt[5] = '{1'b0, 8'h80,  0, 11'b10100000000, 1};
    vt[6] = '{1'b0, 8'hFF,  9, 11'b11111111110, 10};
    vt[7] = '{1'b1, 8'hA5, -1, 11'b11101001010, 11};

    a_reset = 1'b1; a_valid = 1'b0; a_inhibit = 1'b0; a_data = 8'h00;
    b_reset = 1'b1; b_valid = 1'b0; b_inhibit = 1'b0; b_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_a", 32'(obs(1'b0)), 32'(6'b110001));
    check("reset_b", 32'(obs(1'b1)), 32'(6'b110001));
    @(negedge clk);
    a_reset = 1'b0;
    b_reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(vt[i].sb, vt[i].data, vt[i].inh, got, nf);
      check($sformatf("vec%0d_falls", i), 32'(nf), 32'(vt[i].falls));
      for (int j = 0; j < vt[i].falls && j < 11; j++)
        check($sformatf("vec%0d_bit%0d", i, j), 32'(got[j]), 32'(vt[i].frame[j]));
    end

    back_to_back(1'b0, 192);
    back_to_back(1'b1, 45);

    // Inhibit held in idle blocks the handshake; releasing it accepts in that cycle.
    set_inh(1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("inh_idle", 32'(obs(1'b0)), 32'(6'b110000));
    end
    @(negedge clk);
    set_inh(1'b0, 1'b0);
    #1;
    check("inh_release_ready", 32'(a_ready), 32'(1));
    c = cyc;
    check_frame(1'b0, c, 8'hC3, -1, got, nf);
    check("inh_release_falls", 32'(nf), 32'(11));

    // Reset in the middle of bit 6.
    drive(1'b0, 1'b1, 8'h5A);
    wait_accept(1'b0, c);
    if (c >= 0) begin
      for (int k = 1; k <= 6 * 4 * QA + 6; k++) begin
        @(negedge clk);
        if (k == 1) drive(1'b0, 1'b0, 8'h5A);
      end
      a_reset = 1'b1;
      @(negedge clk);
      #1;
      check("reset_mid_frame", 32'(obs(1'b0)), 32'(6'b110001));
      a_reset = 1'b0;
    end else begin
      drive(1'b0, 1'b0, 8'h5A);
    end
    send(1'b0, 8'h96, -1, got, nf);
    check("post_reset_frame", 32'(got), 32'(ref_frame(8'h96)));

    for (int i = 0; i < 12; i++) begin
      sb  = bit'($urandom_range(0, 1));
      d   = 8'($urandom);
      inh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
      fb  = ref_frame(d);
      send(sb, d, inh, got, nf);
      check($sformatf("rand%0d_falls", i), 32'(nf), 32'((inh < 0) ? 11 : inh + 1));
      for (int j = 0; j < nf && j < 11; j++)
        check($sformatf("rand%0d_bit%0d", i, j), 32'(got[j]), 32'(fb[j]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
